// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared state type, widths and round-robin helper for the I2C bus arbiter
package i2c_arb_pkg;

  localparam int OWNER_W = 3;
  localparam int CNT_W   = 24;
  localparam int MAX_REQ = 8;
  localparam int STEP_W  = 5;
  // Bus clear walks 9 SCL pulses as 18 low/high half-periods; step 18 is the STOP half-period.
  localparam int CLEAR_HALVES = 18;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CLEAR,
    GUARD
  } arb_state_t;

  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] cur, input int n_req);
    if (int'(cur) >= n_req - 1) return '0;
    return cur + OWNER_W'(1);
  endfunction

endpackage

// File: rtl/i2c_arb_rr.sv
// rtl/i2c_arb_rr.sv - combinational round-robin picker: first set request at or after rr_ptr, wrapping
module i2c_arb_rr
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] index
);

  logic               hi_found;
  logic [OWNER_W-1:0] hi_idx;
  logic [OWNER_W-1:0] lo_idx;

  // Descending scan leaves the lowest matching index in each candidate.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = OWNER_W'(k);
        if (k >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = OWNER_W'(k);
        end
      end
    end
  end

  assign valid = |req;
  assign index = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - shares one open-drain SCL/SDA pad pair between N masters
// with round-robin grant, bus-free guard, hold timeout and 9-pulse bus clear.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int CLK_DIV        = 206,
  parameter int BUF_CYCLES     = 163,
  parameter int TIMEOUT_CYCLES = 1250000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [N_REQ-1:0]   scl_low,
  input  logic [N_REQ-1:0]   sda_low,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic [N_REQ-1:0]   grant,
  output logic               scl_oe,
  output logic               sda_oe,
  output logic               busy,
  output logic [OWNER_W-1:0] owner,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  BUF_LOAD  = CNT_W'(BUF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0] STOP_STEP = STEP_W'(CLEAR_HALVES);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_q, rr_d;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;
  logic               terr_q, terr_d;

  // Widened copies so the 3-bit owner index selects without width mismatch.
  logic [MAX_REQ-1:0] req_x, done_x, scl_x, sda_x;
  logic               pick_valid;
  logic [OWNER_W-1:0] pick_idx;

  assign req_x  = MAX_REQ'(req);
  assign done_x = MAX_REQ'(done);
  assign scl_x  = MAX_REQ'(scl_low);
  assign sda_x  = MAX_REQ'(sda_low);

  i2c_arb_rr #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    step_d   = step_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    terr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        grant_d  = '0;
        // A low pad means someone outside the arbiter still holds the bus.
        if (pick_valid && scl_in && sda_in) begin
          for (int k = 0; k < N_REQ; k++) begin
            grant_d[k] = (pick_idx == OWNER_W'(k));
          end
          owner_d = pick_idx;
          cnt_d   = TO_LOAD;
          state_d = GRANT;
        end
      end

      GRANT: begin
        scl_oe_d = scl_x[owner_q];
        sda_oe_d = sda_x[owner_q];
        if (done_x[owner_q] || !req_x[owner_q]) begin
          grant_d  = '0;
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
          rr_d     = rr_next(owner_q, N_REQ);
          cnt_d    = BUF_LOAD;
          state_d  = GUARD;
        end else if (cnt_q == '0) begin
          grant_d  = '0;
          terr_d   = 1'b1;
          scl_oe_d = 1'b1;
          sda_oe_d = 1'b0;
          step_d   = '0;
          cnt_d    = DIV_LOAD;
          state_d  = CLEAR;
        end
      end

      CLEAR: begin
        if (cnt_q == '0) begin
          if (step_q == STOP_STEP) begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            rr_d     = rr_next(owner_q, N_REQ);
            cnt_d    = BUF_LOAD;
            state_d  = GUARD;
          end else begin
            step_d   = step_q + STEP_W'(1);
            cnt_d    = DIV_LOAD;
            // Even half-periods hold SCL low; the STOP half-period holds SDA low with SCL high.
            scl_oe_d = (step_d == STOP_STEP) ? 1'b0 : !step_d[0];
            sda_oe_d = (step_d == STOP_STEP);
          end
        end
      end

      GUARD: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        grant_d  = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant       = grant_q;
  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed and randomized checks of i2c_bus_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

  localparam int N = 3;
  localparam int D = 4;
  localparam int B = 10;
  localparam int T = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, done, scl_low, sda_low;
  logic         scl_in, sda_in;
  logic [N-1:0] grant;
  logic         scl_oe, sda_oe, busy, timeout_err;
  logic [2:0]   owner;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .N_REQ          (N),
    .CLK_DIV        (D),
    .BUF_CYCLES     (B),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .scl_low     (scl_low),
    .sda_low     (sda_low),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .grant       (grant),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  int tests = 0;
  int fails = 0;
  int m_ptr = 0;
  int cur   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    return N'(1) << w;
  endfunction

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference: first requester at or after the pointer, wrapping at N.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (bitof(r, (ptr + i) % N)) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_grant(input logic [N-1:0] r, input string tag);
    int w;
    w = pick(r, m_ptr);
    req = r;
    tick();
    chk({tag, " grant"}, 32'(grant), 32'(onehot(w)));
    chk({tag, " owner"}, 32'(owner), 32'(w));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " scl_oe at grant"}, 32'(scl_oe), 32'd0);
    cur = w;
  endtask

  task automatic hold(input int cycles, input string tag);
    logic [N-1:0] sl, dl;
    for (int c = 0; c < cycles; c++) begin
      sl = N'($urandom);
      dl = N'($urandom);
      scl_low = sl;
      sda_low = dl;
      done = N'($urandom) & ~onehot(cur);
      tick();
      chk({tag, " hold grant"}, 32'(grant), 32'(onehot(cur)));
      chk({tag, " hold scl_oe"}, 32'(scl_oe), 32'(bitof(sl, cur)));
      chk({tag, " hold sda_oe"}, 32'(sda_oe), 32'(bitof(dl, cur)));
    end
    done = '0;
  endtask

  task automatic guard_len(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    chk({tag, " guard cycles"}, 32'(n), 32'(B));
    chk({tag, " idle grant"}, 32'(grant), 32'd0);
  endtask

  task automatic release_and_guard(input bit abandon, input string tag);
    if (abandon) req = req & ~onehot(cur);
    else done = onehot(cur);
    scl_low = '1;
    sda_low = '1;
    tick();
    done = '0;
    req = '0;
    scl_low = '0;
    sda_low = '0;
    chk({tag, " rel grant"}, 32'(grant), 32'd0);
    chk({tag, " rel scl_oe"}, 32'(scl_oe), 32'd0);
    chk({tag, " rel sda_oe"}, 32'(sda_oe), 32'd0);
    chk({tag, " rel terr"}, 32'(timeout_err), 32'd0);
    m_ptr = (cur + 1) % N;
    guard_len(tag);
  endtask

  task automatic run_timeout(input string tag, input int reset_after);
    int n, bad, ph;
    logic es, ed;
    n = 1;
    while (n <= T + 50) begin
      tick();
      if (grant === '0) break;
      n++;
    end
    req = '0;
    chk({tag, " grant hold cycles"}, 32'(n), 32'(T));
    chk({tag, " terr pulse"}, 32'(timeout_err), 32'd1);
    if (reset_after >= 0) begin
      repeat (reset_after) tick();
      reset = 1'b1;
      tick();
      chk({tag, " rst grant"}, 32'(grant), 32'd0);
      chk({tag, " rst scl_oe"}, 32'(scl_oe), 32'd0);
      chk({tag, " rst sda_oe"}, 32'(sda_oe), 32'd0);
      chk({tag, " rst busy"}, 32'(busy), 32'd0);
      chk({tag, " rst owner"}, 32'(owner), 32'd0);
      chk({tag, " rst terr"}, 32'(timeout_err), 32'd0);
      reset = 1'b0;
      m_ptr = 0;
    end else begin
      bad = 0;
      for (int c = 0; c < 19 * D; c++) begin
        ph = c / D;
        es = (ph < 18) ? (ph % 2 == 0) : 1'b0;
        ed = (ph >= 18);
        if (scl_oe !== es || sda_oe !== ed || grant !== '0 || busy !== 1'b1) bad++;
        if (c == 1) chk({tag, " terr width"}, 32'(timeout_err), 32'd0);
        tick();
      end
      chk({tag, " clear waveform errors"}, 32'(bad), 32'd0);
      chk({tag, " post-clear scl_oe"}, 32'(scl_oe), 32'd0);
      chk({tag, " post-clear sda_oe"}, 32'(sda_oe), 32'd0);
      m_ptr = (cur + 1) % N;
      guard_len(tag);
    end
  endtask

  task automatic wait_next_grant(input string tag);
    int n;
    n = 0;
    while (grant === '0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " release-to-grant"}, 32'(n), 32'(B + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    int w;
    reset = 1'b1;
    req = '0; done = '0; scl_low = '0; sda_low = '0;
    scl_in = 1'b1; sda_in = 1'b1;
    tick();
    tick();
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset scl_oe", 32'(scl_oe), 32'd0);
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset terr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle no req busy", 32'(busy), 32'd0);

    sda_in = 1'b0;
    req = 3'b001;
    repeat (5) tick();
    chk("bus held grant", 32'(grant), 32'd0);
    chk("bus held busy", 32'(busy), 32'd0);
    sda_in = 1'b1;
    do_grant(3'b001, "held");
    hold(3, "held");
    release_and_guard(1'b0, "held");

    do_grant(3'b011, "timeout");
    run_timeout("timeout", -1);
    do_grant(3'b111, "ptr after clear");
    release_and_guard(1'b0, "ptr after clear");

    do_grant(3'b001, "done+timeout");
    repeat (T - 1) tick();
    done = onehot(cur);
    tick();
    done = '0;
    req = '0;
    chk("done+timeout grant", 32'(grant), 32'd0);
    chk("done+timeout terr", 32'(timeout_err), 32'd0);
    chk("done+timeout busy", 32'(busy), 32'd1);
    m_ptr = (cur + 1) % N;
    guard_len("done+timeout");

    do_grant(3'b010, "rst clear");
    run_timeout("rst clear", 2 * D + 1);
    do_grant(3'b011, "after reset");

    scl_low = 3'b010;
    sda_low = 3'b010;
    tick();
    chk("isolation scl_oe", 32'(scl_oe), 32'd0);
    chk("isolation sda_oe", 32'(sda_oe), 32'd0);
    scl_low = 3'b011;
    sda_low = 3'b001;
    tick();
    chk("owner drive scl_oe", 32'(scl_oe), 32'd1);
    chk("owner drive sda_oe", 32'(sda_oe), 32'd1);
    scl_low = '0;
    sda_low = '0;

    done = 3'b001;
    tick();
    done = '0;
    chk("fair rel0 grant", 32'(grant), 32'd0);
    m_ptr = (cur + 1) % N;
    w = pick(req, m_ptr);
    wait_next_grant("fair 0->1");
    chk("fair second grant", 32'(grant), 32'(onehot(w)));
    chk("fair second owner", 32'(owner), 32'(w));
    cur = w;
    done = onehot(cur);
    tick();
    done = '0;
    m_ptr = (cur + 1) % N;
    w = pick(req, m_ptr);
    wait_next_grant("fair 1->0");
    chk("fair third grant", 32'(grant), 32'(onehot(w)));
    cur = w;
    release_and_guard(1'b0, "fair end");

    for (int it = 0; it < 40; it++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      do_grant(r, "rnd");
      hold($urandom_range(1, 12), "rnd");
      release_and_guard(1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
